mac_operand_sequencer: RTL and testbench
========================================

Name: mac_operand_sequencer

Overview:
- Upstream feeder for the MAC stage; holds one NxN A matrix and one NxN B matrix of 4-bit elements.
- On start, computes each C[i][j] as a dot product by streaming pairs A[i][k], B[k][j] into the MAC on w/x.
- Drives the MAC load/clear controls with timing matched to the MAC's registered multiplier and negedge accumulator.
- Flags each cycle in which the MAC output o holds a finished element.

Parameters:
- N, 2, matrix dimension (N >= 2).
- DW, 4, element width; equals MAC operand width.
- Derived localparam AW = $clog2(N); address width = 2*AW.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for the operand store.
- wr_sel  in  1  0 = write A, 1 = write B.
- wr_addr  in  2*AW  element index, row*N+col.
- wr_data  in  DW  element value.
- start  in  1  begin full-matrix sequence (single-cycle pulse).
- mac_w  out  DW  to MAC w.
- mac_x  out  DW  to MAC x.
- mac_load  out  1  to MAC load.
- mac_clear  out  1  to MAC clear.
- busy  out  1  high while sequencing.
- res_valid  out  1  MAC o holds final C[res_row][res_col] this cycle.
- res_row  out  AW  row index of the current result.
- res_col  out  AW  column index of the current result.
- done  out  1  one-cycle pulse after the last result.

Behaviour:
- All outputs are registered.
- Reset (async): state IDLE; all outputs 0; both matrix stores cleared to 0; i, j, k counters 0.
- Writes: accepted on posedge when wr_en=1 and busy=0; ignored while busy=1.
- start with busy=1: ignored.
- start and wr_en in the same cycle with busy=0: the write commits; the sequence uses the new value.
- FSM, one state per output cycle:
  - IDLE: all control outputs 0. start -> CLEAR.
  - CLEAR (1 cycle): mac_clear=1, mac_load=0. The MAC accumulator zeroes at the negedge of this cycle. -> STREAM with k=0.
  - STREAM (N cycles, k=0..N-1): mac_w=A[i][k], mac_x=B[k][j]. The MAC registers the product at the closing posedge.
    - mac_load = registered copy of "STREAM active", so it is 1 in STREAM k>=1 and in DRAIN, and 0 in STREAM k=0.
    - Each product is therefore added exactly once, at the negedge after it is registered.
  - DRAIN (1 cycle): mac_load=1 adds the last product. mac_w and mac_x hold their last values. -> EMIT.
  - EMIT (1 cycle): mac_load=0, res_valid=1, res_row=i, res_col=j. The consumer samples MAC o at the posedge ending EMIT.
    - Advance order: j first, then i.
    - If i=N-1 and j=N-1 -> DONE; else -> CLEAR.
- DONE (1 cycle): done=1, busy=0 next cycle -> IDLE.
- busy=1 from the cycle after start is sampled through EMIT of the last element.
- Latency:
  - Each element takes N+3 cycles.
  - First res_valid occurs in cycle N+3 after the start edge.
  - done is high in cycle N*N*(N+3)+1 after the start edge.
- Width: sums wrap mod 2^8 in the MAC. The sequencer does no arithmetic unless the optional feature is enabled.
- res_row/res_col hold their last values outside EMIT; only res_valid qualifies them.
- rst mid-sequence: immediate return to IDLE, outputs 0, no done pulse. A new start restarts from C[0][0].

Optional Feature:
- Macro: MAC_SEQ_OVF_FLAG_EN.
- Defined:
  - Adds output res_ovf (1 bit).
  - An internal shadow accumulator of width 2*DW+$clog2(N)+1 tracks each product sum with the same clear/load timing.
  - res_ovf=1 during EMIT when the shadow sum > 255.
  - res_ovf is 0 outside EMIT and is reset to 0.
- Undefined: no res_ovf port and no shadow logic.

Test Plan:
- Basic product: N=2; write A=[[1,2],[3,4]], B=[[5,6],[7,8]]; start -> res_valid pulses four times, MAC o = 19, 22, 43, 50 at (row,col) = (0,0), (0,1), (1,0), (1,1); done one cycle after the 4th pulse.
- Latency: start at edge E0 -> mac_clear=1 in cycle 1; first res_valid in cycle 5; done in cycle 21; busy=1 over cycles 1-20.
- Control timing per element: cycles show mac_clear=1,0,0,0,0 and mac_load=0,0,1,1,0 across CLEAR, STREAM0, STREAM1, DRAIN, EMIT.
- Write blocking: wr_en during busy with A[0][0]=9 -> ignored; a rerun still gives 19 for C[0][0]. A second start while busy -> no effect on the sequence.
- Reset mid-run: assert rst in cycle 7 -> all outputs 0 immediately, no done. Reload A and B, start -> correct results from (0,0).
- Overflow (MAC_SEQ_OVF_FLAG_EN): all elements 15 -> each o = 194 (450 mod 256) and res_ovf=1. With the matrices from the basic test -> res_ovf=0 throughout.

Source files
------------

// File: rtl/mac_operand_sequencer_if.sv
// Operand-write, start and MAC-drive bundle for mac_operand_sequencer.
// Carries res_ovf only when MAC_SEQ_OVF_FLAG_EN is defined.
interface mac_operand_sequencer_if #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 4
);
    localparam int unsigned AW = $clog2(N);

    logic            wr_en;
    logic            wr_sel;
    logic [2*AW-1:0] wr_addr;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic [DW-1:0]   mac_w;
    logic [DW-1:0]   mac_x;
    logic            mac_load;
    logic            mac_clear;
    logic            busy;
    logic            res_valid;
    logic [AW-1:0]   res_row;
    logic [AW-1:0]   res_col;
    logic            done;
`ifdef MAC_SEQ_OVF_FLAG_EN
    logic            res_ovf;
`endif

    modport master (
`ifdef MAC_SEQ_OVF_FLAG_EN
        input  res_ovf,
`endif
        output wr_en, wr_sel, wr_addr, wr_data, start,
        input  mac_w, mac_x, mac_load, mac_clear, busy,
        input  res_valid, res_row, res_col, done
    );

    modport slave (
`ifdef MAC_SEQ_OVF_FLAG_EN
        output res_ovf,
`endif
        input  wr_en, wr_sel, wr_addr, wr_data, start,
        output mac_w, mac_x, mac_load, mac_clear, busy,
        output res_valid, res_row, res_col, done
    );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Streams A-row/B-column operand pairs into a MAC to form C = A x B, one element per N+3 cycles.
// Optional macro MAC_SEQ_OVF_FLAG_EN adds res_ovf from a full-width shadow accumulator.
module mac_operand_sequencer #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 4
) (
    input logic                    clk,
    input logic                    rst,
    mac_operand_sequencer_if.slave bus
);
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned IW = 2 * AW;
    localparam int unsigned NN = N * N;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        EMIT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t        state;
    logic [DW-1:0] a_mem [NN];
    logic [DW-1:0] b_mem [NN];
    logic [AW-1:0] i_q;
    logic [AW-1:0] j_q;
    logic [AW-1:0] k_q;
    logic [AW-1:0] k_nx;
    logic          last_k;
    logic          last_j;
    logic          last_i;
    logic          wr_ok;

    function automatic logic [IW-1:0] idx(input logic [AW-1:0] r, input logic [AW-1:0] c);
        return IW'(r) * IW'(N) + IW'(c);
    endfunction

    assign k_nx   = k_q + AW'(1);
    assign last_k = (k_q == AW'(N - 1));
    assign last_j = (j_q == AW'(N - 1));
    assign last_i = (i_q == AW'(N - 1));
    assign wr_ok  = bus.wr_en && !bus.busy && (32'(bus.wr_addr) < NN);

    // Outputs are loaded on the edge that enters the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            bus.mac_w     <= '0;
            bus.mac_x     <= '0;
            bus.mac_load  <= 1'b0;
            bus.mac_clear <= 1'b0;
            bus.busy      <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_row   <= '0;
            bus.res_col   <= '0;
            bus.done      <= 1'b0;
            for (int n = 0; n < NN; n++) begin
                a_mem[n] <= '0;
                b_mem[n] <= '0;
            end
        end else begin
            if (wr_ok) begin
                if (bus.wr_sel) b_mem[bus.wr_addr] <= bus.wr_data;
                else            a_mem[bus.wr_addr] <= bus.wr_data;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= CLEAR;
                        i_q           <= '0;
                        j_q           <= '0;
                        bus.mac_clear <= 1'b1;
                        bus.busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    state         <= STREAM;
                    k_q           <= '0;
                    bus.mac_clear <= 1'b0;
                    bus.mac_w     <= a_mem[idx(i_q, '0)];
                    bus.mac_x     <= b_mem[idx('0, j_q)];
                end
                STREAM: begin
                    // load lags the stream by one cycle to meet the MAC's registered product
                    bus.mac_load <= 1'b1;
                    if (last_k) begin
                        state <= DRAIN;
                    end else begin
                        k_q       <= k_nx;
                        bus.mac_w <= a_mem[idx(i_q, k_nx)];
                        bus.mac_x <= b_mem[idx(k_nx, j_q)];
                    end
                end
                DRAIN: begin
                    state         <= EMIT;
                    bus.mac_load  <= 1'b0;
                    bus.res_valid <= 1'b1;
                    bus.res_row   <= i_q;
                    bus.res_col   <= j_q;
                end
                EMIT: begin
                    bus.res_valid <= 1'b0;
                    if (last_i && last_j) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else begin
                        state         <= CLEAR;
                        bus.mac_clear <= 1'b1;
                        if (last_j) begin
                            j_q <= '0;
                            i_q <= i_q + AW'(1);
                        end else begin
                            j_q <= j_q + AW'(1);
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAC_SEQ_OVF_FLAG_EN
    localparam int unsigned PW = 2 * DW;
    localparam int unsigned SW = 2 * DW + $clog2(N) + 1;

    logic [PW-1:0] sh_prod;
    logic [SW-1:0] sh_acc;
    logic [SW-1:0] sh_sum;

    assign sh_sum = sh_acc + SW'(sh_prod);

    // Posedge mirror of the MAC: the negedge add in cycle c becomes the update at the edge closing c.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_prod     <= '0;
            sh_acc      <= '0;
            bus.res_ovf <= 1'b0;
        end else begin
            sh_prod <= PW'(bus.mac_w) * PW'(bus.mac_x);
            if (bus.mac_clear)     sh_acc <= '0;
            else if (bus.mac_load) sh_acc <= sh_sum;
            bus.res_ovf <= (state == DRAIN) && (sh_sum > SW'(255));
        end
    end
`endif
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Self-checking bench: external MAC model plus matrix-product reference and per-cycle timing rules.
module tb_mac_operand_sequencer;
    localparam int unsigned N  = 2;
    localparam int unsigned DW = 4;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned IW = 2 * AW;
    localparam int EL = N + 3;
    localparam int T  = N * N * EL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_operand_sequencer_if #(.N(N), .DW(DW)) bus ();
    mac_operand_sequencer #(.N(N), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Downstream MAC: registered multiplier on posedge, 8-bit accumulator on negedge.
    logic [7:0] mac_p = 8'd0;
    logic [7:0] mac_o = 8'd0;
    always @(posedge clk) mac_p <= 8'(bus.mac_w) * 8'(bus.mac_x);
    always @(negedge clk) begin
        if (bus.mac_clear)     mac_o <= 8'd0;
        else if (bus.mac_load) mac_o <= mac_o + mac_p;
    end

    int tests = 0;
    int fails = 0;
    int ma [N][N];
    int mb [N][N];
    int got [N*N];

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        tests++;
        assert (obs === 32'(exp)) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit sel, input int r, input int c, input int v);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = IW'(r * N + c);
        bus.wr_data = DW'(v);
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
        if (sel) mb[r][c] = v;
        else     ma[r][c] = v;
    endtask

    // mode 0: basic matrices, 1: random, 2: all fifteen
    task automatic load(input int mode);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                int av, bv;
                if (mode == 0) begin
                    av = r * N + c + 1;
                    bv = r * N + c + 5;
                end else if (mode == 1) begin
                    av = int'($urandom_range(0, 15));
                    bv = int'($urandom_range(0, 15));
                end else begin
                    av = 15;
                    bv = 15;
                end
                wr(1'b0, r, c, av);
                wr(1'b1, r, c, bv);
            end
    endtask

    task automatic run(input string nm, input bit disturb, input int abort_at, input bit wr_at_start);
        int  c [N][N];
        int  e, p, r, cc, kk;
        bit  ec, el, ev, eb, ed, in_seq;
        @(negedge clk);
        bus.start = 1'b1;
        if (wr_at_start) begin
            mb[N-1][N-1] = (mb[N-1][N-1] + 7) % 16;
            bus.wr_en    = 1'b1;
            bus.wr_sel   = 1'b1;
            bus.wr_addr  = IW'(N * N - 1);
            bus.wr_data  = DW'(mb[N-1][N-1]);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                c[i][j] = 0;
                for (int k = 0; k < N; k++) c[i][j] += ma[i][k] * mb[k][j];
            end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        for (int t = 1; t <= T + 2; t++) begin
            e  = (t - 1) / EL;
            p  = (t - 1) % EL;
            r  = e / N;
            cc = e % N;
            if (t == abort_at) begin
                rst = 1'b1;
                #1;
                chk({nm, " rst_ctrl"}, 32'({bus.mac_clear, bus.mac_load, bus.res_valid, bus.busy, bus.done}), 0);
                chk({nm, " rst_wx"}, 32'({bus.mac_w, bus.mac_x}), 0);
                chk({nm, " rst_rc"}, 32'({bus.res_row, bus.res_col}), 0);
                repeat (2) @(posedge clk);
                @(negedge clk) rst = 1'b0;
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        ma[i][j] = 0;
                        mb[i][j] = 0;
                    end
                for (int q = 0; q < 10; q++) begin
                    @(posedge clk);
                    #1 chk({nm, " no_done"}, 32'({bus.busy, bus.done}), 0);
                end
                return;
            end
            in_seq = (t <= T);
            ec = in_seq && (p == 0);
            el = in_seq && (p >= 2) && (p <= N + 1);
            ev = in_seq && (p == N + 2);
            eb = in_seq;
            ed = (t == T + 1);
            chk($sformatf("%s ctrl t%0d", nm, t),
                32'({bus.mac_clear, bus.mac_load, bus.res_valid, bus.busy, bus.done}),
                int'({ec, el, ev, eb, ed}));
            if (in_seq && p >= 1 && p <= N + 1) begin
                kk = (p <= N) ? p - 1 : N - 1;
                chk($sformatf("%s w t%0d", nm, t), 32'(bus.mac_w), ma[r][kk]);
                chk($sformatf("%s x t%0d", nm, t), 32'(bus.mac_x), mb[kk][cc]);
            end
            if (ev) begin
                chk($sformatf("%s row e%0d", nm, e), 32'(bus.res_row), r);
                chk($sformatf("%s col e%0d", nm, e), 32'(bus.res_col), cc);
                chk($sformatf("%s o e%0d", nm, e), 32'(mac_o), c[r][cc] % 256);
                got[e] = int'(mac_o);
            end
`ifdef MAC_SEQ_OVF_FLAG_EN
            chk($sformatf("%s ovf t%0d", nm, t), 32'(bus.res_ovf), int'(ev && (c[r][cc] > 255)));
`endif
            @(negedge clk);
            if (disturb && t == 3) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_addr = '0;
                bus.wr_data = DW'(9);
                bus.start   = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.wr_en = 1'b0;
            bus.start = 1'b0;
        end
    endtask

    initial begin
        int basic_c [4] = '{19, 22, 43, 50};
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 0;
                mb[i][j] = 0;
            end

        repeat (2) @(posedge clk);
        #1;
        chk("reset ctrl", 32'({bus.mac_clear, bus.mac_load, bus.res_valid, bus.busy, bus.done}), 0);
        chk("reset wx", 32'({bus.mac_w, bus.mac_x}), 0);
        chk("reset rc", 32'({bus.res_row, bus.res_col}), 0);
        @(negedge clk) rst = 1'b0;

        load(0);
        run("basic", 1'b0, 0, 1'b0);
        for (int e = 0; e < 4; e++) chk($sformatf("basic const e%0d", e), 32'(got[e]), basic_c[e]);

        run("blocked", 1'b1, 0, 1'b0);
        run("rerun", 1'b0, 0, 1'b0);
        chk("rerun c00", 32'(got[0]), 19);

        run("abort", 1'b0, 7, 1'b0);
        run("cleared", 1'b0, 0, 1'b0);
        load(0);
        run("reload", 1'b0, 0, 1'b0);
        run("wr_start", 1'b0, 0, 1'b1);

        for (int n = 0; n < 3; n++) begin
            load(1);
            run($sformatf("rand%0d", n), 1'b0, 0, 1'b0);
        end

        load(2);
        run("all15", 1'b0, 0, 1'b0);
        chk("all15 c11", 32'(got[3]), 194);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
